qspi_slave: RTL and testbench
=============================

Name: qspi_slave

Overview:
QSPI target that answers the QSPI master peripheral. It lets a second SoC instance, or the loopback test harness, act as the flash-side device.
- All pins are oversampled on the system clock: no logic is clocked by sclk.
- Exposes a 32-byte memory window to the QSPI link (quad-I/O read, write and status commands).
- The same window, plus status/debug registers, is visible on the local byte-enabled register bus used by the other peripherals.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk_i, cs_ni, io_i.
- DUMMY_CYCLES, 4, sclk cycles between address and first read nibble (0xEB only).
- ADDR_BYTES, 3, address bytes sent by the master (3 means 6 quad clocks).

Ports:
- clk_i  in  1  system clock; sclk_i must satisfy f(clk_i) >= 8*f(sclk).
- rst_i  in  1  synchronous reset, active-high.
- sclk_i  in  1  QSPI serial clock from the master.
- cs_ni  in  1  chip select, active-low.
- io_i  in  4  QSPI data lines, input side.
- io_o  out  4  QSPI data lines, output value.
- io_oe_o  out  4  per-line output enable; the tristate is done at top level.
- write_i  in  1  local-bus write strobe.
- data_be_i  in  4  byte enables.
- addr_i  in  6  local-bus byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, combinational from addr_i/data_be_i.
- irq_o  out  1  one-cycle pulse at the end of each QSPI write transaction.

Behaviour:
- Reset values: io_o=0, io_oe_o=0, irq_o=0; state=IDLE; STATUS=0, LAST_CMD=0, LAST_ADDR=0. Memory is not reset.
- Synchronizers: sclk_i, cs_ni and io_i each pass through SYNC_STAGES flops. Edge detection uses the synchronized sclk and its last-stage delay.
- Edges: a rising edge samples io; a falling edge updates io_o. Mode 0 only; sclk idles low.
- Bit order: all phases are quad, 4 bits per sclk. Each byte is sent high nibble first. Address is big-endian. Memory bytes are little-endian within words.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STAT, IGNORE.
- IDLE -> CMD on synchronized cs_n falling; resets the nibble counter.
- CMD: 2 rising edges build the command byte, which is latched into LAST_CMD. Then:
  - 0xEB goes to ADDR (read).
  - 0x32 goes to ADDR (write).
  - 0x05 goes to STAT.
  - Any other command goes to IGNORE.
- ADDR: 2*ADDR_BYTES rising edges, then the address is latched into LAST_ADDR.
  - 0xEB goes to DUMMY; if DUMMY_CYCLES=0 it goes directly to RDATA.
  - 0x32 goes to WDATA.
  - Only addr[4:0] is used, so all addresses wrap modulo 32.
- DUMMY: counts DUMMY_CYCLES rising edges. io_oe_o stays 0 throughout.
- RDATA:
  - On the first falling edge after the last dummy rising edge, set io_oe_o=4'hF and drive the high nibble of mem[addr].
  - Each following falling edge drives the next nibble.
  - After the low nibble, addr increments and wraps 31 -> 0. The read streams until cs_n rises.
- STAT: drives {6'b0, STATUS[1:0]} repeatedly, using the same timing as RDATA.
- WDATA:
  - Two rising edges form a byte, written to mem[addr]; then addr increments with wrap.
  - Sets STATUS[1] (write-received, sticky).
  - A partial byte (1 nibble) at cs_n rise is discarded.
- IGNORE: no output and no state change until cs_n rises.
- cs_n rise from any state: next cycle state=IDLE and io_oe_o=0. If the aborted command was 0x32 and at least one byte was written, irq_o pulses for 1 cycle.
- STATUS register:
  - bit0 = busy, which equals synchronized cs_n low (live).
  - bit1 = write-received; cleared by a local-bus write of 1 to bit1 (W1C).
- Local map: 0x00 STATUS (RO/W1C); 0x04 LAST_CMD[7:0] (RO); 0x08 LAST_ADDR[23:0] (RO); 0x20-0x3F memory (RW, byte enables honoured).
- Unmapped local reads return 0; unmapped writes are ignored.
- A local-bus read returns bytes addr_i+i for each enabled data_be_i[i]. Disabled lanes read 0.
- Collision: a local write and a QSPI write to the same byte in the same cycle resolve in favour of the QSPI write. Local writes to other bytes proceed.
- Reset mid-transaction: FSM returns to IDLE and io_oe_o=0. The current cs_n-low period is then treated as IGNORE until cs_n rises.

Test Plan:
- Local write 0x20=0x44332211, 0x24=0x88776655. Master sends 0xEB, addr 0x000000, 4 dummy cycles, 16 nibbles -> io nibbles 1,1,2,2,3,3,4,4,5,5,6,6,7,7,8,8. io_oe_o=F only after dummy. LAST_CMD=0xEB.
- Master sends 0x32, addr 0x00001E, bytes A5 5A C3 -> mem bytes 0x1E=A5, 0x1F=5A, 0x00=C3 (wrap). irq_o pulses once after cs_n rises. STATUS reads 0x2 when idle.
- Master sends 0x05 while STATUS[1]=1 -> io nibbles 0,3 repeating (busy=1). A local write of 0x2 to 0x00, then 0x05 again -> nibbles 0,1.
- Unknown command 0x9F followed by 10 clocks -> io_oe_o stays 0, memory unchanged, LAST_CMD=0x9F, no irq.
- Write 0x32 with 3 nibbles of data (1.5 bytes) -> only the first byte is stored and the trailing nibble is dropped. Then rst_i asserted mid-0xEB read -> io_oe_o=0 within 1 cycle and no drive until the next cs_n fall.
- Same-cycle local write 0x20=0xFFFFFFFF (be=F) and QSPI write of byte 0x00=0x12 -> mem word 0x20 reads 0xFFFFFF12.

Source files
------------

// File: rtl/qspi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : qspi_slave
//  Purpose  : Quad-I/O SPI target with a 32-byte memory window, oversampled
//             on the system clock, plus a byte-enabled local register bus.
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_slave #(
    parameter int SYNC_STAGES  = 2,
    parameter int DUMMY_CYCLES = 4,
    parameter int ADDR_BYTES   = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        cs_ni,
    input  logic [3:0]  io_i,
    output logic [3:0]  io_o,
    output logic [3:0]  io_oe_o,
    input  logic        write_i,
    input  logic [3:0]  data_be_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam logic [7:0] c_CMD_READ   = 8'hEB;
    localparam logic [7:0] c_CMD_WRITE  = 8'h32;
    localparam logic [7:0] c_CMD_STAT   = 8'h05;
    localparam logic [7:0] c_ADDR_LAST  = 8'(2 * ADDR_BYTES - 1);
    localparam logic [7:0] c_DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_STAT   = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [3:0]             r_io_sync [SYNC_STAGES];
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_nib_sel;
    logic [3:0]  r_nib;
    logic [23:0] r_addr_sh;
    logic [4:0]  r_ptr;
    logic [7:0]  r_last_cmd;
    logic [23:0] r_last_addr;
    logic        r_wr_recv;
    logic        r_wr_any;
    logic [7:0]  r_mem [32];

    // cs_n chain resets to "asserted" so a select held low across reset never
    // shows a falling edge: that low period is ignored until cs_n rises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) r_io_sync[i] <= 4'h0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], cs_ni};
            r_io_sync[0] <= io_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_io_sync[i] <= r_io_sync[i-1];
            r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d       <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic        w_sclk, w_cs_n, w_rise, w_fall, w_cs_fall, w_cs_rise;
    logic [3:0]  w_io;
    logic [23:0] w_addr_next;
    logic [7:0]  w_rd_byte, w_byte_wr;
    logic        w_qspi_we, w_clr_wr;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_io        = r_io_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs_n & r_cs_d;
    assign w_cs_rise   = w_cs_n & ~r_cs_d;
    assign w_addr_next = {r_addr_sh[19:0], w_io};
    assign w_byte_wr   = {r_nib, w_io};
    assign w_rd_byte   = (r_state == S_STAT) ? {6'b0, r_wr_recv, ~w_cs_n} : r_mem[r_ptr];
    assign w_qspi_we   = !rst_i && (r_state == S_WDATA) && w_rise && r_nib_sel && !w_cs_rise;
    assign w_clr_wr    = write_i && data_be_i[0] && (addr_i == 6'd0) && wdata_i[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_nib_sel   <= 1'b0;
            r_nib       <= 4'h0;
            r_addr_sh   <= 24'd0;
            r_ptr       <= 5'd0;
            r_last_cmd  <= 8'h00;
            r_last_addr <= 24'd0;
            r_wr_recv   <= 1'b0;
            r_wr_any    <= 1'b0;
            io_o        <= 4'h0;
            io_oe_o     <= 4'h0;
            irq_o       <= 1'b0;
        end else begin
            irq_o <= 1'b0;
            if (w_clr_wr) r_wr_recv <= 1'b0;
            if (w_cs_rise) begin
                r_state  <= S_IDLE;
                io_oe_o  <= 4'h0;
                irq_o    <= (r_last_cmd == c_CMD_WRITE) && r_wr_any;
                r_wr_any <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_cs_fall) begin
                        r_state   <= S_CMD;
                        r_cnt     <= 8'd0;
                        r_nib_sel <= 1'b0;
                        r_wr_any  <= 1'b0;
                    end
                    S_CMD: if (w_rise) begin
                        r_nib_sel <= ~r_nib_sel;
                        if (!r_nib_sel) begin
                            r_nib <= w_io;
                        end else begin
                            r_last_cmd <= {r_nib, w_io};
                            r_cnt      <= 8'd0;
                            case ({r_nib, w_io})
                                c_CMD_READ, c_CMD_WRITE: r_state <= S_ADDR;
                                c_CMD_STAT:              r_state <= S_STAT;
                                default:                 r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_addr_sh <= w_addr_next;
                        if (r_cnt == c_ADDR_LAST) begin
                            r_last_addr <= w_addr_next;
                            r_ptr       <= w_addr_next[4:0];
                            r_cnt       <= 8'd0;
                            r_nib_sel   <= 1'b0;
                            if (r_last_cmd == c_CMD_WRITE) r_state <= S_WDATA;
                            else if (DUMMY_CYCLES == 0)    r_state <= S_RDATA;
                            else                           r_state <= S_DUMMY;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_DUMMY: if (w_rise) begin
                        if (r_cnt == c_DUMMY_LAST) r_state <= S_RDATA;
                        else                       r_cnt   <= r_cnt + 8'd1;
                    end
                    S_RDATA, S_STAT: if (w_fall) begin
                        io_oe_o   <= 4'hF;
                        io_o      <= r_nib_sel ? w_rd_byte[3:0] : w_rd_byte[7:4];
                        r_nib_sel <= ~r_nib_sel;
                        if (r_nib_sel && r_state == S_RDATA) r_ptr <= r_ptr + 5'd1;
                    end
                    S_WDATA: if (w_rise) begin
                        r_nib_sel <= ~r_nib_sel;
                        if (!r_nib_sel) begin
                            r_nib <= w_io;
                        end else begin
                            r_ptr     <= r_ptr + 5'd1;
                            r_wr_recv <= 1'b1;
                            r_wr_any  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [6:0] w_lane_addr [4];

    function automatic logic [7:0] f_rd_byte(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a[6:5] == 2'b01) begin
            v = r_mem[a[4:0]];
        end else begin
            case (a)
                7'h00:   v = {6'b0, r_wr_recv, ~w_cs_n};
                7'h04:   v = r_last_cmd;
                7'h08:   v = r_last_addr[7:0];
                7'h09:   v = r_last_addr[15:8];
                7'h0A:   v = r_last_addr[23:16];
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_addr[g]  = {1'b0, addr_i} + 7'(g);
        assign rdata_o[8*g +: 8] = data_be_i[g] ? f_rd_byte(w_lane_addr[g]) : 8'h00;
    end

    // The QSPI write is last so it wins a same-byte collision with the bus.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (write_i && data_be_i[i] && w_lane_addr[i][6:5] == 2'b01)
                r_mem[w_lane_addr[i][4:0]] <= wdata_i[8*i +: 8];
        end
        if (w_qspi_we) r_mem[r_ptr] <= w_byte_wr;
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qspi_slave
//  Purpose  : Self-checking bench for qspi_slave: vector table, directed QSPI
//             sequences and randomized traffic against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_slave;
    localparam int HALF = 50;

    logic        clk_i = 1'b0, rst_i, sclk_i, cs_ni, write_i;
    logic [3:0]  io_i, data_be_i, io_o, io_oe_o;
    logic [5:0]  addr_i;
    logic [31:0] wdata_i, rdata_o;
    logic        irq_o;

    qspi_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .cs_ni(cs_ni),
        .io_i(io_i), .io_o(io_o), .io_oe_o(io_oe_o), .write_i(write_i),
        .data_be_i(data_be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_err = 0, irq_cnt = 0, rst_at = -1;
    logic [7:0]  m [32];
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic        m_wr;
    logic [3:0]  tx_q[$], rx_q[$], oe_q[$];
    logic [7:0]  wq[$];

    always @(negedge clk_i) if (irq_o) irq_cnt++;

    typedef struct {
        bit          wr;
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mb(input int a);
        if (a >= 32 && a < 64) return m[a-32];
        case (a)
            0:       return {6'b0, m_wr, 1'b0};
            4:       return m_cmd;
            8:       return m_addr[7:0];
            9:       return m_addr[15:8];
            10:      return m_addr[23:16];
            default: return 8'h00;
        endcase
    endfunction

    task automatic lb_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk_i);
        addr_i = a; data_be_i = be; wdata_i = d; write_i = 1'b1;
        @(negedge clk_i);
        write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (int'(a) + i >= 32 && int'(a) + i < 64) m[int'(a) + i - 32] = d[8*i +: 8];
                if (int'(a) + i == 0 && d[1]) m_wr = 1'b0;
            end
        end
    endtask

    task automatic lb_read(input logic [5:0] a, input logic [3:0] be, output logic [31:0] d);
        @(negedge clk_i);
        addr_i = a; data_be_i = be; write_i = 1'b0;
        #1 d = rdata_o;
    endtask

    task automatic lb_check(input string nm, input logic [5:0] a, input logic [3:0] be);
        logic [31:0] e, d;
        e = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) e[8*i +: 8] = mb(int'(a) + i);
        lb_read(a, be, d);
        chk(nm, d, e);
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_q.push_back(b[7:4]);
        tx_q.push_back(b[3:0]);
    endtask

    task automatic push_hdr(input logic [7:0] cmd, input logic [23:0] a);
        tx_q.delete();
        push_byte(cmd);
        push_byte(a[23:16]); push_byte(a[15:8]); push_byte(a[7:0]);
    endtask

    task automatic run_xfer(input bit keep_cs);
        rx_q.delete(); oe_q.delete();
        cs_ni = 1'b0; #(HALF);
        for (int k = 0; k < tx_q.size(); k++) begin
            io_i = tx_q[k]; #(HALF);
            rx_q.push_back(io_o); oe_q.push_back(io_oe_o);
            if (k == rst_at) begin
                @(posedge clk_i); #1 rst_i = 1'b1;
                @(posedge clk_i); #1 rst_i = 1'b0;
                chk("rst_oe", 32'(io_oe_o), 32'h0);
            end
            sclk_i = 1'b1; #(HALF); sclk_i = 1'b0;
        end
        if (!keep_cs) begin
            #(HALF); cs_ni = 1'b1; #(3*HALF);
        end
    endtask

    task automatic qspi_read(input logic [23:0] a, input int n);
        logic [3:0] acc;
        logic [7:0] b;
        int i0;
        push_hdr(8'hEB, a);
        repeat (4) tx_q.push_back(4'h0);
        repeat (2*n) tx_q.push_back(4'($urandom));
        i0 = irq_cnt;
        run_xfer(1'b0);
        m_cmd = 8'hEB; m_addr = a;
        acc = 4'h0;
        for (int k = 0; k < 12; k++) acc |= oe_q[k];
        chk("rd_oe_pre", 32'(acc), 32'h0);
        for (int d = 0; d < 2*n; d++) begin
            b = m[(int'(a[4:0]) + d/2) % 32];
            chk("rd_nib", 32'({oe_q[12+d], rx_q[12+d]}),
                32'({4'hF, (d % 2) ? b[3:0] : b[7:4]}));
        end
        chk("rd_irq", 32'(irq_cnt - i0), 32'h0);
    endtask

    task automatic qspi_write(input logic [23:0] a, input bit extra, input logic [3:0] xn);
        logic [3:0] acc;
        int i0;
        push_hdr(8'h32, a);
        foreach (wq[j]) push_byte(wq[j]);
        if (extra) tx_q.push_back(xn);
        i0 = irq_cnt;
        run_xfer(1'b0);
        m_cmd = 8'h32; m_addr = a;
        foreach (wq[j]) m[(int'(a[4:0]) + j) % 32] = wq[j];
        if (wq.size() > 0) m_wr = 1'b1;
        acc = 4'h0;
        foreach (oe_q[k]) acc |= oe_q[k];
        chk("wr_oe", 32'(acc), 32'h0);
        chk("wr_irq", 32'(irq_cnt - i0), (wq.size() > 0) ? 32'h1 : 32'h0);
    endtask

    task automatic qspi_stat(input int n);
        tx_q.delete();
        push_byte(8'h05);
        repeat (2*n) tx_q.push_back(4'($urandom));
        run_xfer(1'b0);
        m_cmd = 8'h05;
        chk("st_oe_pre", 32'(oe_q[0] | oe_q[1]), 32'h0);
        for (int d = 0; d < 2*n; d++)
            chk("st_nib", 32'({oe_q[2+d], rx_q[2+d]}),
                32'({4'hF, (d % 2) ? {2'b0, m_wr, 1'b1} : 4'h0}));
    endtask

    initial begin
        logic [31:0] d;
        logic [63:0] v;
        logic [3:0]  acc;
        int          i0, op;

        tbl[0]  = '{1'b0, 6'h00, 4'hF, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 6'h04, 4'hF, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 6'h08, 4'hF, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 6'h20, 4'hF, 32'h44332211, 32'h0};
        tbl[4]  = '{1'b1, 6'h24, 4'hF, 32'h88776655, 32'h0};
        tbl[5]  = '{1'b0, 6'h20, 4'hF, 32'h0,        32'h44332211};
        tbl[6]  = '{1'b0, 6'h22, 4'h3, 32'h0,        32'h00004433};
        tbl[7]  = '{1'b0, 6'h21, 4'hF, 32'h0,        32'h55443322};
        tbl[8]  = '{1'b1, 6'h24, 4'h4, 32'hAABBCCDD, 32'h0};
        tbl[9]  = '{1'b0, 6'h24, 4'h5, 32'h0,        32'h00BB0055};
        tbl[10] = '{1'b1, 6'h10, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[11] = '{1'b0, 6'h10, 4'hF, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 6'h1E, 4'hC, 32'h0,        32'h22110000};
        tbl[13] = '{1'b1, 6'h24, 4'hF, 32'h88776655, 32'h0};
        tbl[14] = '{1'b0, 6'h24, 4'hF, 32'h0,        32'h88776655};

        rst_i = 1'b1; sclk_i = 1'b0; cs_ni = 1'b1; io_i = 4'h0; write_i = 1'b0;
        data_be_i = 4'h0; addr_i = 6'h0; wdata_i = 32'h0;
        m_cmd = 8'h0; m_addr = 24'h0; m_wr = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b0;
        chk("rst_io", 32'(io_o), 32'h0);
        chk("rst_oe", 32'(io_oe_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        repeat (10) @(negedge clk_i);

        for (int t = 0; t < 15; t++) begin
            if (tbl[t].wr) lb_write(tbl[t].a, tbl[t].be, tbl[t].d);
            else begin
                lb_read(tbl[t].a, tbl[t].be, d);
                chk($sformatf("tbl%0d", t), d, tbl[t].exp);
            end
        end

        // quad read of the first two words
        qspi_read(24'h000000, 8);
        for (int k = 0; k < 16; k++) v[63 - 4*k -: 4] = rx_q[12+k];
        chk("tp_rd_hi", v[63:32], 32'h11223344);
        chk("tp_rd_lo", v[31:0], 32'h55667788);
        lb_read(6'h04, 4'h1, d); chk("tp_lastcmd_eb", d, 32'hEB);

        // write that wraps from byte 31 to byte 0
        wq = '{8'hA5, 8'h5A, 8'hC3};
        qspi_write(24'h00001E, 1'b0, 4'h0);
        lb_read(6'h3E, 4'h3, d); chk("tp_wr_wrap", d, 32'h00005AA5);
        lb_read(6'h20, 4'h1, d); chk("tp_wr_b0", d, 32'h000000C3);
        lb_read(6'h00, 4'h1, d); chk("tp_status", d, 32'h00000002);

        qspi_stat(3);
        lb_write(6'h00, 4'h1, 32'h2);
        lb_read(6'h00, 4'hF, d); chk("w1c", d, 32'h0);
        qspi_stat(2);

        // unknown command is ignored
        tx_q.delete(); push_byte(8'h9F);
        repeat (10) tx_q.push_back(4'($urandom));
        i0 = irq_cnt;
        run_xfer(1'b0);
        m_cmd = 8'h9F;
        acc = 4'h0;
        foreach (oe_q[k]) acc |= oe_q[k];
        chk("unk_oe", 32'(acc), 32'h0);
        chk("unk_irq", 32'(irq_cnt - i0), 32'h0);
        lb_read(6'h04, 4'h1, d); chk("unk_lastcmd", d, 32'h9F);
        lb_check("unk_mem0", 6'h20, 4'hF);
        lb_check("unk_mem1", 6'h3C, 4'hF);

        // trailing half byte is dropped
        wq = '{8'h7E};
        qspi_write(24'h000005, 1'b1, 4'h9);
        lb_read(6'h25, 4'h1, d); chk("part_b5", d, 32'h0000007E);
        lb_check("part_b6", 6'h26, 4'h1);

        // same-cycle bus write and QSPI write to byte 0
        tx_q.delete(); push_byte(8'h32); push_byte(8'h00); push_byte(8'h00); push_byte(8'h00);
        tx_q.push_back(4'h1);
        i0 = irq_cnt;
        run_xfer(1'b1);
        #(HALF); io_i = 4'h2; #(HALF);
        @(posedge clk_i); #1 sclk_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i);
        #1 addr_i = 6'h20; data_be_i = 4'hF; wdata_i = 32'hFFFFFFFF; write_i = 1'b1;
        @(posedge clk_i); #1 write_i = 1'b0;
        #(HALF); sclk_i = 1'b0; #(HALF); cs_ni = 1'b1; #(3*HALF);
        m[0] = 8'h12; m[1] = 8'hFF; m[2] = 8'hFF; m[3] = 8'hFF;
        m_cmd = 8'h32; m_addr = 24'h0; m_wr = 1'b1;
        lb_read(6'h20, 4'hF, d); chk("collide", d, 32'hFFFFFF12);
        chk("collide_irq", 32'(irq_cnt - i0), 32'h1);

        // reset in the middle of a read
        push_hdr(8'hEB, 24'h000003);
        repeat (8) tx_q.push_back(4'h0);
        rst_at = 13;
        i0 = irq_cnt;
        run_xfer(1'b0);
        rst_at = -1;
        m_cmd = 8'h0; m_addr = 24'h0; m_wr = 1'b0;
        chk("rst_rd0", 32'({oe_q[12], rx_q[12]}), 32'({4'hF, m[3][7:4]}));
        chk("rst_rd1", 32'({oe_q[13], rx_q[13]}), 32'({4'hF, m[3][3:0]}));
        chk("rst_quiet", 32'(oe_q[14] | oe_q[15]), 32'h0);
        chk("rst_irq", 32'(irq_cnt - i0), 32'h0);
        lb_check("rst_regs0", 6'h00, 4'hF);
        lb_check("rst_regs1", 6'h08, 4'hF);
        qspi_stat(1);

        // randomized traffic against the byte-array model
        for (int w = 0; w < 8; w++) lb_write(6'(6'h20 + 4*w), 4'hF, $urandom);
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    d = $urandom;
                    addr_i = 6'($urandom);
                    lb_write(addr_i, 4'($urandom), d);
                    lb_check("rnd_lbw", addr_i, 4'hF);
                end
                1: lb_check("rnd_lbr", 6'($urandom), 4'($urandom));
                2: qspi_read(24'($urandom), $urandom_range(1, 5));
                default: begin
                    wq.delete();
                    repeat ($urandom_range(0, 4)) wq.push_back(8'($urandom));
                    qspi_write(24'($urandom), 1'($urandom), 4'($urandom));
                    lb_check("rnd_status", 6'h00, 4'hF);
                    lb_check("rnd_addr", 6'h08, 4'hF);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
